// File: rtl/Types.sv
// Shared types for the pulse scheduler/arbiter block.
package Types;
    localparam int ARB_N_REQ = 4;

    typedef enum logic [1:0] {IDLE, START, WAIT} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: rotate pending flags so the search origin is bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    logic [SEL_W:0]   start;
    logic [SEL_W:0]   enc;
    logic [SEL_W:0]   sum;
    logic [N_REQ-1:0] rot;

    always_comb begin
        // N_REQ need not be a power of two, so wrap explicitly
        start = {1'b0, last} + (SEL_W+1)'(1);
        if (start >= (SEL_W+1)'(N_REQ))
            start = '0;
        rot = N_REQ'({pend, pend} >> start);
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i])
                enc = (SEL_W+1)'(i);
        sum = enc + start;
        if (sum >= (SEL_W+1)'(N_REQ))
            sum = sum - (SEL_W+1)'(N_REQ);
        gnt_idx = SEL_W'(sum);
        gnt_vld = |pend;
    end
endmodule

// File: rtl/pls_sched_arb.sv
// Round-robin scheduler sharing one readout engine among N_REQ pulse lanes,
// with start/done handshake, completion timeout and overrun drop counter.
module pls_sched_arb
    import Types::*;
#(
    parameter int N_REQ   = ARB_N_REQ,
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [N_REQ-1:0]         pls_in,
    input  logic                     eng_done,
    input  logic                     clr_err,
    output logic                     eng_start,
    output logic [$clog2(N_REQ)-1:0] eng_sel,
    output logic                     busy,
    output logic [N_REQ-1:0]         pend,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     tmo_err,
    output logic [$clog2(N_REQ)-1:0] tmo_lane
);
    localparam int SEL_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TMO_CYC);
    localparam int SUM_W = CNT_W + SEL_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] last;
    logic [TMR_W-1:0] timer;
    logic [SEL_W-1:0] win;
    logic             win_vld;
    logic             grant;
    logic             tmo;
    logic             hit;
    logic [N_REQ-1:0] pend_n;
    logic [SEL_W:0]   drop_num;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_n;

    rr_pick #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_pick (
        .pend    (pend),
        .last    (last),
        .gnt_idx (win),
        .gnt_vld (win_vld)
    );

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE:
                if (en && win_vld) begin
                    state_n = START;
                    grant   = 1'b1;
                end
            START:
                state_n = WAIT;
            WAIT:
                if (eng_done)
                    state_n = IDLE;
                else if (timer == TMR_W'(TMO_CYC - 1)) begin
                    state_n = IDLE;
                    tmo     = 1'b1;
                end
            default:
                state_n = IDLE;
        endcase
    end

    // A re-pulse on the lane being granted re-arms it instead of counting as a drop
    always_comb begin
        pend_n   = '0;
        drop_num = '0;
        hit      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            hit       = grant && (win == SEL_W'(i));
            pend_n[i] = pls_in[i] | (pend[i] & ~hit);
            if (pls_in[i] && pend[i] && !hit)
                drop_num = drop_num + (SEL_W+1)'(1);
        end
        cnt_sum = (clr_err ? '0 : SUM_W'(drop_cnt)) + SUM_W'(drop_num);
        cnt_n   = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= SEL_W'(N_REQ - 1);
            timer     <= '0;
            eng_start <= 1'b0;
            eng_sel   <= '0;
            busy      <= 1'b0;
            pend      <= '0;
            drop_cnt  <= '0;
            tmo_err   <= 1'b0;
            tmo_lane  <= '0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            drop_cnt  <= cnt_n;
            eng_start <= (state_n == START);
            busy      <= (state_n != IDLE);
            if (grant) begin
                eng_sel <= win;
                last    <= win;
                timer   <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TMR_W'(1);
            end
            if (tmo) begin
                tmo_err  <= 1'b1;
                tmo_lane <= eng_sel;
            end else if (clr_err) begin
                tmo_err  <= 1'b0;
                tmo_lane <= '0;
            end
        end
    end
endmodule
